// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor constants and direction type for the elevator front end
package elevator_pkg;
  localparam int NUM_FLOORS = 3;
  localparam int FLOOR_W = 2;
  typedef enum logic [1:0] {DIR_IDLE, DIR_UP, DIR_DOWN} dir_t;
  localparam logic [FLOOR_W-1:0] FLOOR_0 = 2'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd2;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, stability counter and rising-edge detect for one button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_pulse
);
  logic sync1, sync2, prev;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      stable_out <= 1'b0;
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      prev <= stable_out;
      if (sync2 == stable_out) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_out <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign rise_pulse = stable_out & ~prev;
endmodule

// File: rtl/elevator_request_manager.sv
// elevator_request_manager: debounces call/select buttons, latches pending requests until serviced
module elevator_request_manager
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_up_0,
  input  logic                  call_up_1,
  input  logic                  call_down_1,
  input  logic                  call_down_2,
  input  logic                  select_floor_0,
  input  logic                  select_floor_1,
  input  logic                  select_floor_2,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  input  logic                  moving_up,
  input  logic                  moving_down,
  output logic [1:0]            pending_up,
  output logic [1:0]            pending_down,
  output logic [NUM_FLOORS-1:0] pending_car,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  any_req
);
  logic [6:0] raw, stable, rise, set_req;
  logic [NUM_FLOORS-1:0] at;
  logic [1:0] clr_up, clr_down;
  logic svc;
  dir_t last_dir;
  assign raw = {select_floor_2, select_floor_1, select_floor_0, call_down_2, call_down_1, call_up_1, call_up_0};
  for (genvar i = 0; i < 7; i++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw_in(raw[i]),
      .stable_out(stable[i]),
      .rise_pulse(rise[i])
    );
  end
  assign set_req = rise & stable;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_dir <= DIR_IDLE;
    else if (moving_up && !moving_down) last_dir <= DIR_UP;
    else if (moving_down && !moving_up) last_dir <= DIR_DOWN;
  assign svc = door_open && current_floor <= FLOOR_2;
  assign at = {svc && current_floor == FLOOR_2, svc && current_floor == FLOOR_1, svc && current_floor == FLOOR_0};
  // Floor 1 hall calls stay latched if the car is still heading toward a waiting request beyond it
  assign clr_up = {at[1] && !(last_dir == DIR_DOWN && floor_req[0]), at[0]};
  assign clr_down = {at[2], at[1] && !(last_dir == DIR_UP && floor_req[2])};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_up <= '0;
      pending_down <= '0;
      pending_car <= '0;
    end else begin
      pending_up <= (pending_up | set_req[1:0]) & ~clr_up;
      pending_down <= (pending_down | set_req[3:2]) & ~clr_down;
      pending_car <= (pending_car | set_req[6:4]) & ~at;
    end
  assign floor_req = {pending_down[1] | pending_car[2],
                      pending_up[1] | pending_down[0] | pending_car[1],
                      pending_up[0] | pending_car[0]};
  assign any_req = |floor_req;
  always_comb begin
    req_above = (current_floor == FLOOR_0) ? |floor_req[2:1] :
                (current_floor == FLOOR_1) ? floor_req[2] : 1'b0;
    req_below = (current_floor == FLOOR_1) ? floor_req[0] :
                (current_floor == FLOOR_2) ? |floor_req[1:0] : 1'b0;
  end
endmodule

// File: tb/tb_elevator_request_manager.sv
// tb_elevator_request_manager: directed checks of debounce, latching, service clears and summaries
module tb_elevator_request_manager;
  logic clk = 1'b0;
  logic rst_n;
  logic call_up_0, call_up_1, call_down_1, call_down_2;
  logic select_floor_0, select_floor_1, select_floor_2;
  logic [1:0] current_floor;
  logic door_open, moving_up, moving_down;
  logic [1:0] pending_up, pending_down;
  logic [2:0] pending_car, floor_req;
  logic req_above, req_below, any_req;
  int vectors = 0;
  int miscompares = 0;

  elevator_request_manager #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_up_0(call_up_0), .call_up_1(call_up_1),
    .call_down_1(call_down_1), .call_down_2(call_down_2),
    .select_floor_0(select_floor_0), .select_floor_1(select_floor_1), .select_floor_2(select_floor_2),
    .current_floor(current_floor), .door_open(door_open),
    .moving_up(moving_up), .moving_down(moving_down),
    .pending_up(pending_up), .pending_down(pending_down), .pending_car(pending_car),
    .floor_req(floor_req), .req_above(req_above), .req_below(req_below), .any_req(any_req)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_buttons(input logic v);
    call_up_0 = v; call_up_1 = v; call_down_1 = v; call_down_2 = v;
    select_floor_0 = v; select_floor_1 = v; select_floor_2 = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_buttons(1'b0);
    current_floor = 2'd0; door_open = 1'b0; moving_up = 1'b0; moving_down = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset with every button held high
    rst_n = 1'b0;
    set_buttons(1'b1);
    current_floor = 2'd0; door_open = 1'b0; moving_up = 1'b0; moving_down = 1'b0;
    step(3);
    chk("rst_up", 32'(pending_up), 0);
    chk("rst_down", 32'(pending_down), 0);
    chk("rst_car", 32'(pending_car), 0);
    chk("rst_freq", 32'(floor_req), 0);
    chk("rst_any", 32'(any_req), 0);
    chk("rst_above", 32'(req_above), 0);
    rst_n = 1'b1;
    step(1);
    chk("rel_e1_car", 32'(pending_car), 0);
    step(5);
    chk("rel_e6_car", 32'(pending_car), 0);
    step(1);
    chk("rel_e7_car", 32'(pending_car), 'b111);
    chk("rel_e7_up", 32'(pending_up), 'b11);
    chk("rel_e7_down", 32'(pending_down), 'b11);
    chk("rel_e7_freq", 32'(floor_req), 'b111);

    // car select floor 2 from floor 0
    do_reset();
    select_floor_2 = 1'b1;
    step(6);
    chk("sel2_e6", 32'(pending_car), 0);
    step(1);
    chk("sel2_e7", 32'(pending_car), 'b100);
    chk("sel2_freq", 32'(floor_req), 'b100);
    chk("sel2_above", 32'(req_above), 1);
    chk("sel2_below", 32'(req_below), 0);
    chk("sel2_any", 32'(any_req), 1);
    step(13);
    select_floor_2 = 1'b0;
    step(10);
    chk("sel2_held", 32'(pending_car), 'b100);
    current_floor = 2'd3; door_open = 1'b1;
    step(2);
    chk("cf3_noclr", 32'(pending_car), 'b100);
    chk("cf3_above", 32'(req_above), 0);
    chk("cf3_below", 32'(req_below), 0);
    current_floor = 2'd2; door_open = 1'b0;
    step(1);
    chk("cf2_above", 32'(req_above), 0);
    chk("cf2_below", 32'(req_below), 0);
    door_open = 1'b1;
    step(1);
    chk("svc2_car", 32'(pending_car), 0);
    chk("svc2_any", 32'(any_req), 0);
    door_open = 1'b0;

    // glitch shorter than the debounce window, then exactly the window
    current_floor = 2'd0;
    call_up_1 = 1'b1;
    step(3);
    call_up_1 = 1'b0;
    step(50);
    chk("glitch_up", 32'(pending_up), 0);
    call_up_1 = 1'b1;
    step(4);
    call_up_1 = 1'b0;
    step(3);
    chk("edge4_up", 32'(pending_up), 'b10);
    chk("edge4_above", 32'(req_above), 1);
    current_floor = 2'd1; door_open = 1'b1;
    step(1);
    chk("edge4_clr", 32'(pending_up), 0);
    door_open = 1'b0;

    // floor 1 with last_dir=UP and a request above
    do_reset();
    moving_up = 1'b1;
    step(1);
    moving_up = 1'b0;
    call_up_1 = 1'b1; call_down_1 = 1'b1; select_floor_2 = 1'b1;
    step(7);
    chk("f1u_up", 32'(pending_up), 'b10);
    chk("f1u_down", 32'(pending_down), 'b01);
    chk("f1u_car", 32'(pending_car), 'b100);
    set_buttons(1'b0);
    step(2);
    current_floor = 2'd1; door_open = 1'b1;
    step(1);
    chk("f1u_upclr", 32'(pending_up), 0);
    chk("f1u_downkeep", 32'(pending_down), 'b01);
    chk("f1u_above", 32'(req_above), 1);
    chk("f1u_below", 32'(req_below), 0);
    current_floor = 2'd2;
    step(1);
    chk("f1u_car2clr", 32'(pending_car), 0);
    chk("f1u_downstay", 32'(pending_down), 'b01);
    current_floor = 2'd1;
    step(1);
    chk("f1u_downclr", 32'(pending_down), 0);
    door_open = 1'b0;

    // floor 1 with last_dir=DOWN and a request below
    moving_down = 1'b1;
    step(1);
    moving_down = 1'b0;
    current_floor = 2'd0;
    select_floor_0 = 1'b1; call_up_1 = 1'b1;
    step(7);
    chk("f1d_car", 32'(pending_car), 'b001);
    chk("f1d_up", 32'(pending_up), 'b10);
    set_buttons(1'b0);
    current_floor = 2'd1; door_open = 1'b1;
    step(1);
    chk("f1d_upkeep", 32'(pending_up), 'b10);
    chk("f1d_below", 32'(req_below), 1);
    current_floor = 2'd0;
    step(1);
    chk("f1d_car0clr", 32'(pending_car), 0);
    chk("f1d_upstay", 32'(pending_up), 'b10);
    current_floor = 2'd1;
    step(1);
    chk("f1d_upclr", 32'(pending_up), 0);
    door_open = 1'b0;

    // press held across a reset pulse
    do_reset();
    call_down_2 = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(2);
    chk("rsthold_in", 32'(pending_down), 0);
    rst_n = 1'b1;
    step(6);
    chk("rsthold_e6", 32'(pending_down), 0);
    step(1);
    chk("rsthold_e7", 32'(pending_down), 'b10);
    call_down_2 = 1'b0;

    // press matures while the door is open at that floor
    do_reset();
    current_floor = 2'd2; door_open = 1'b1;
    call_down_2 = 1'b1;
    step(7);
    chk("clrwin_e7", 32'(pending_down), 0);
    step(5);
    chk("clrwin_e12", 32'(pending_down), 0);
    door_open = 1'b0;
    step(3);
    chk("clrwin_norearm", 32'(pending_down), 0);
    call_down_2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
